// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants for the multi-port register file.
//                Optional macro REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_RD_MAX   = 4;
    localparam int NUM_WR       = 2;
    // Write port that wins a same-address collision.
    localparam int WR_PRIO_PORT = 1;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG_EN  = 1'b1;
`else
    localparam bit ZERO_REG_EN  = 1'b0;
`endif

    // True when an access to this address must be suppressed because
    // entry 0 is hardwired.
    function automatic logic zero_reg_hit(input logic addr_is_zero);
        return ZERO_REG_EN && addr_is_zero;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_if
//  Description : Read, write and scoreboard-set bus of the register file.
//                master = decode/writeback side, slave = register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en_i;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic [NUM_WR-1:0]        wr_en_i;
    logic [NUM_WR*ADDR_W-1:0] wr_addr_i;
    logic [NUM_WR*DATA_W-1:0] wr_data_i;
    logic                     sb_set_i;
    logic [ADDR_W-1:0]        sb_addr_i;

    modport master (
        output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               sb_set_i, sb_addr_i,
        input  rd_data_o, rd_busy_o
    );

    modport slave (
        input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               sb_set_i, sb_addr_i,
        output rd_data_o, rd_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register pending bits. Writes clear, sb_set sets, and a
//                set beats a same-cycle clear. Exposes the next-state vector
//                so read ports see this cycle's updates.
//                Honors REGFILE_ZERO_REG_EN (entry 0 never becomes pending).
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  wire logic                     clk_i,
    input  wire logic                     rst_i,
    input  wire logic                     set_i,
    input  wire logic [ADDR_W-1:0]        set_addr_i,
    input  wire logic [NUM_WR-1:0]        clr_en_i,
    input  wire logic [NUM_WR*ADDR_W-1:0] clr_addr_i,
    output logic [(1<<ADDR_W)-1:0]        pend_d_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Apply completing-producer clears first, then the new producer's set.
    always_comb begin
        pend_d = pend_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (clr_en_i[p]) begin
                pend_d[clr_addr_i[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (set_i && !zero_reg_hit(set_addr_i == '0)) begin
            pend_d[set_addr_i] = 1'b1;
        end
    end

    // Pending state register; reset discards all in-flight producers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_d_o = pend_d;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised register file, NUM_RD registered read ports
//                with write-first bypass, two write ports (port 1 wins on
//                same-address collision) and a pending scoreboard.
//                Macro REGFILE_ZERO_REG_EN makes entry 0 hardwired zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [NUM_WR-1:0]        wr_en_eff;
    logic [DEPTH-1:0]         pend_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q;
    logic [NUM_RD-1:0]        rd_busy_d;
    logic [NUM_RD-1:0]        rd_busy_q;

    // Drop writes aimed at a hardwired zero entry so they neither store,
    // bypass nor clear pending.
    always_comb begin
        wr_en_eff = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_en_eff[p] = bus.wr_en_i[p] &&
                           !zero_reg_hit(bus.wr_addr_i[p*ADDR_W +: ADDR_W] == '0);
        end
    end

    regfile_scoreboard #(
        .ADDR_W     (ADDR_W)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (bus.sb_set_i),
        .set_addr_i (bus.sb_addr_i),
        .clr_en_i   (wr_en_eff),
        .clr_addr_i (bus.wr_addr_i),
        .pend_d_o   (pend_d)
    );

    // Storage update; the priority port is applied last so it wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (p != WR_PRIO_PORT && wr_en_eff[p]) begin
                    mem_q[bus.wr_addr_i[p*ADDR_W +: ADDR_W]] <= bus.wr_data_i[p*DATA_W +: DATA_W];
                end
            end
            if (wr_en_eff[WR_PRIO_PORT]) begin
                mem_q[bus.wr_addr_i[WR_PRIO_PORT*ADDR_W +: ADDR_W]] <=
                    bus.wr_data_i[WR_PRIO_PORT*DATA_W +: DATA_W];
            end
        end
    end

    // Per-port read mux: stored value, overridden by same-cycle writes with
    // the priority port checked last; busy uses the next-state pending bit.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_d[k*DATA_W +: DATA_W] = mem_q[bus.rd_addr_i[k*ADDR_W +: ADDR_W]];
            for (int p = 0; p < NUM_WR; p++) begin
                if (p != WR_PRIO_PORT && wr_en_eff[p] &&
                    bus.wr_addr_i[p*ADDR_W +: ADDR_W] == bus.rd_addr_i[k*ADDR_W +: ADDR_W]) begin
                    rd_data_d[k*DATA_W +: DATA_W] = bus.wr_data_i[p*DATA_W +: DATA_W];
                end
            end
            if (wr_en_eff[WR_PRIO_PORT] &&
                bus.wr_addr_i[WR_PRIO_PORT*ADDR_W +: ADDR_W] == bus.rd_addr_i[k*ADDR_W +: ADDR_W]) begin
                rd_data_d[k*DATA_W +: DATA_W] = bus.wr_data_i[WR_PRIO_PORT*DATA_W +: DATA_W];
            end
            rd_busy_d[k] = pend_d[bus.rd_addr_i[k*ADDR_W +: ADDR_W]];
        end
    end

    // Read output registers; disabled ports hold their last result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (bus.rd_en_i[k]) begin
                    rd_data_q[k*DATA_W +: DATA_W] <= rd_data_d[k*DATA_W +: DATA_W];
                    rd_busy_q[k]                  <= rd_busy_d[k];
                end
            end
        end
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.rd_busy_o = rd_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp with a behavioural model
//                (arrays of stored values and pending bits), directed cases
//                and randomized traffic. Honors REGFILE_ZERO_REG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_pend [DEPTH];
    logic [DW-1:0] n_mem  [DEPTH];
    bit            n_pend [DEPTH];
    logic [DW-1:0] e_rd   [NR];
    bit            e_busy [NR];
    bit            m_valid = 1'b0;

    function automatic bit zero_blocked(input int a);
`ifdef REGFILE_ZERO_REG_EN
        return a == 0;
`else
        return 1'b0;
`endif
    endfunction

    // Register file state after the edge; a read returns the post-edge
    // state of its entry, which is exactly write-first behaviour.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            for (int k = 0; k < NR; k++) begin
                e_rd[k]   = '0;
                e_busy[k] = 1'b0;
            end
        end else begin
            n_mem  = m_mem;
            n_pend = m_pend;
            for (int p = 0; p < 2; p++) begin
                int a;
                a = int'(bus.wr_addr_i[p*AW +: AW]);
                if (bus.wr_en_i[p] && !zero_blocked(a)) begin
                    n_mem[a]  = bus.wr_data_i[p*DW +: DW];
                    n_pend[a] = 1'b0;
                end
            end
            if (bus.sb_set_i && !zero_blocked(int'(bus.sb_addr_i)))
                n_pend[int'(bus.sb_addr_i)] = 1'b1;
            for (int k = 0; k < NR; k++) begin
                int a;
                a = int'(bus.rd_addr_i[k*AW +: AW]);
                if (bus.rd_en_i[k]) begin
                    e_rd[k]   = n_mem[a];
                    e_busy[k] = n_pend[a];
                end
            end
            m_mem  = n_mem;
            m_pend = n_pend;
        end
        m_valid = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on every cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < NR; k++) begin
                check($sformatf("model rd_data[%0d]", k), 64'(bus.rd_data_o[k*DW +: DW]), 64'(e_rd[k]));
                check($sformatf("model rd_busy[%0d]", k), 64'(bus.rd_busy_o[k]), 64'(e_busy[k]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.rd_en_i   = '0;
        bus.rd_addr_i = '0;
        bus.wr_en_i   = '0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.sb_set_i  = 1'b0;
        bus.sb_addr_i = '0;
    endtask

    task automatic set_rd(input int k, input bit en, input int a);
        bus.rd_en_i[k]           = en;
        bus.rd_addr_i[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
        bus.wr_en_i[p]            = 1'b1;
        bus.wr_addr_i[p*AW +: AW] = AW'(a);
        bus.wr_data_i[p*DW +: DW] = d;
    endtask

    task automatic set_sb(input int a);
        bus.sb_set_i  = 1'b1;
        bus.sb_addr_i = AW'(a);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rdd(input int k);
        return bus.rd_data_o[k*DW +: DW];
    endfunction

    function automatic int rand_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH-1))
                                           : int'($urandom_range(0, 7));
    endfunction

    initial begin
        // Reset overrides same-cycle writes, set and reads.
        rst = 1'b1;
        idle();
        set_wr(0, 3, 32'h1234_5678);
        set_wr(1, 3, 32'h8765_4321);
        set_rd(0, 1'b1, 3);
        set_rd(1, 1'b1, 3);
        set_sb(3);
        tick();
        tick();
        rst = 1'b0;
        idle();
        set_rd(0, 1'b1, 3);
        set_rd(1, 1'b1, 3);
        tick();
        check("reset rd_data[0]", 64'(rdd(0)), 64'h0);
        check("reset rd_busy[0]", 64'(bus.rd_busy_o[0]), 64'h0);

        // Write-first bypass.
        idle();
        set_wr(0, 7, 32'hDEAD_BEEF);
        set_rd(0, 1'b1, 7);
        tick();
        check("bypass rd_data[0]", 64'(rdd(0)), 64'hDEAD_BEEF);

        // Same-address collision: port 1 wins, both read ports agree.
        idle();
        set_wr(0, 9, 32'h11);
        set_wr(1, 9, 32'h22);
        tick();
        idle();
        set_rd(0, 1'b1, 9);
        set_rd(1, 1'b1, 9);
        tick();
        check("collision rd_data[0]", 64'(rdd(0)), 64'h22);
        check("collision rd_data[1]", 64'(rdd(1)), 64'h22);

        // Scoreboard set, set-beats-clear, then clear.
        idle();
        set_sb(4);
        tick();
        idle();
        set_rd(0, 1'b1, 4);
        tick();
        check("sb set busy", 64'(bus.rd_busy_o[0]), 64'h1);
        idle();
        set_wr(0, 4, 32'h44);
        set_sb(4);
        set_rd(0, 1'b1, 4);
        tick();
        check("sb set+clr busy", 64'(bus.rd_busy_o[0]), 64'h1);
        idle();
        set_wr(1, 4, 32'h45);
        set_rd(0, 1'b1, 4);
        tick();
        check("sb clr busy", 64'(bus.rd_busy_o[0]), 64'h0);

        // Disabled read port holds while address and storage change.
        idle();
        set_wr(0, 10, 32'hA5A5_A5A5);
        tick();
        idle();
        set_rd(1, 1'b1, 10);
        tick();
        check("hold initial rd_data[1]", 64'(rdd(1)), 64'hA5A5_A5A5);
        for (int i = 0; i < 3; i++) begin
            idle();
            set_rd(1, 1'b0, 11 + i);
            set_wr(0, 10, DW'($urandom));
            set_wr(1, 11 + i, DW'($urandom));
            set_rd(0, 1'b1, 10);
            tick();
            check($sformatf("hold rd_data[1] cycle %0d", i), 64'(rdd(1)), 64'hA5A5_A5A5);
        end

        // Entry 0: hardwired zero only when the feature is built in.
        idle();
        set_wr(0, 0, 32'h55);
        set_sb(0);
        tick();
        idle();
        set_rd(0, 1'b1, 0);
        tick();
`ifdef REGFILE_ZERO_REG_EN
        check("zero reg rd_data", 64'(rdd(0)), 64'h0);
        check("zero reg rd_busy", 64'(bus.rd_busy_o[0]), 64'h0);
`else
        check("reg0 rd_data", 64'(rdd(0)), 64'h55);
        check("reg0 rd_busy", 64'(bus.rd_busy_o[0]), 64'h1);
`endif

        // Randomized traffic with occasional mid-operation reset.
        for (int c = 0; c < 600; c++) begin
            idle();
            rst = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < NR; k++)
                set_rd(k, 1'($urandom_range(0, 1)), rand_addr());
            for (int p = 0; p < 2; p++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(p, rand_addr(), DW'($urandom));
            if ($urandom_range(0, 2) == 0)
                set_sb(rand_addr());
            tick();
        end

        rst = 1'b0;
        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the CPU datapath; successor to the fixed 32x32, 2-read/1-write file.
- Adds configurable width, depth and read-port count, a second write port (ports 0 and 1 have equal rank except on same-address collisions), and a registered read stage with write-first bypass.
- Adds a per-register pending scoreboard so decode can detect hazards on in-flight producers.
- Sits between decode (read and scoreboard set) and writeback (write and scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- rd_en_i  in  NUM_RD  per-port read enable
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data_o  out  NUM_RD*DATA_W  registered read data
- rd_busy_o  out  NUM_RD  registered pending flag of the addressed register
- wr_en_i  in  2  write enables, ports 0 and 1
- wr_addr_i  in  2*ADDR_W  write addresses
- wr_data_i  in  2*DATA_W  write data
- sb_set_i  in  1  mark a register pending (producer issued)
- sb_addr_i  in  ADDR_W  scoreboard set address

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset state: all storage entries 0, rd_data_o 0, rd_busy_o 0, all pending bits 0. Reset overrides every same-cycle write, set and read.
- Write:
  - On a rising edge with wr_en_i[p]=1, entry wr_addr_i[p] is loaded with wr_data_i[p].
  - Both ports to the same address in the same cycle: port 1 wins.
- Read latency is 1 cycle. When rd_en_i[k]=1 at edge N, rd_data_o[k] after edge N equals:
  - the value written at edge N, if a write to rd_addr_i[k] occurs in that cycle (write-first bypass; port 1 priority applies);
  - otherwise the stored value.
- rd_en_i[k]=0: rd_data_o[k] and rd_busy_o[k] hold their previous values.
- Scoreboard:
  - A write on either port clears pending[wr_addr].
  - sb_set_i sets pending[sb_addr_i].
  - Set and clear of the same address in the same cycle: set wins, pending ends at 1 (the new producer supersedes the completing one).
- rd_busy_o[k] is registered with rd_data_o[k]. It equals the next-state pending bit of rd_addr_i[k], with same-cycle clears and sets both applied.
- Read ports are fully independent. Any number of ports may address the same entry.
- Reset mid-operation: in-flight pending state is discarded. Writeback after reset still writes data, and clearing an already-clear bit is harmless.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN
- Defined: entry 0 is hardwired zero.
  - Writes to address 0 are ignored, including any bypass of them.
  - Reads of address 0 return 0.
  - sb_set_i to address 0 is ignored, so rd_busy_o is always 0 for address 0.
- Undefined: entry 0 is an ordinary register, identical to all others.

Decomposition:
- Package regfile_pkg holds:
  - default constants DATA_W_DEF, ADDR_W_DEF, NUM_RD_MAX;
  - write-port count constant NUM_WR=2;
  - index constant WR_PRIO_PORT=1.
- One sub-module, regfile_scoreboard:
  - depth-wide pending vector with set/clear priority logic;
  - exposes next-state pending for the read-port lookups.
- Storage, write priority and bypass muxes stay in regfile_mp.

Test Plan:
- Reset then read: assert rst_i with wr_en_i=2'b11 to addr 3 -> after release, read addr 3 gives 0 and rd_busy_o=0.
- Bypass: write 0xDEADBEEF to addr 7 while port 0 reads addr 7 in the same cycle -> rd_data_o[0]=0xDEADBEEF one cycle later.
- Write collision: port 0 writes 0x11 and port 1 writes 0x22 to addr 9 in the same cycle -> a later read of addr 9 gives 0x22, and both read ports agree.
- Scoreboard:
  - sb_set_i to addr 4 -> next read of 4 shows busy=1;
  - then a write to 4 together with sb_set_i to 4 -> busy stays 1;
  - then a write alone -> busy=0.
- Read hold: rd_en_i[1]=0 while its address and storage change -> rd_data_o[1] unchanged for 3 cycles.
- Zero register with REGFILE_ZERO_REG_EN: write 0x55 to addr 0 and sb_set_i to 0 -> read gives 0 and busy=0. Without the macro, the same stimulus reads 0x55 and busy=1.
